// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller between decode and the datapath ALU: accepts one
// decoded op, drives registered ALU operands/control, captures the result and hands it on.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_branch,
    output logic             res_illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_PASS = 4'b1111;

    state_t           state_reg;
    logic             qualify_reg;
    logic             illegal_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [3:0]       alu_control_reg;
    logic             res_valid_reg;
    logic [WIDTH-1:0] res_data_reg;
    logic             res_branch_reg;
    logic             res_illegal_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic [3:0]       dec_control;
    logic             dec_illegal;
    logic [WIDTH-1:0] operand_b;

    // Unsupported encodings select pass-A so the ALU output equals rs_data.
    always_comb begin
        dec_control = CTRL_PASS;
        dec_illegal = 1'b1;
        case (alu_op)
            2'b00: begin
                dec_control = CTRL_ADD;
                dec_illegal = 1'b0;
            end
            2'b01: begin
                dec_control = CTRL_SUB;
                dec_illegal = 1'b0;
            end
            2'b10: begin
                dec_illegal = 1'b0;
                case (funct)
                    6'b100000: dec_control = CTRL_ADD;
                    6'b100010: dec_control = CTRL_SUB;
                    6'b100100: dec_control = CTRL_AND;
                    6'b100101: dec_control = CTRL_OR;
                    6'b101010: dec_control = CTRL_SLT;
                    default: begin
                        dec_control = CTRL_PASS;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_control = CTRL_PASS;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign operand_b = use_imm ? imm : rt_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            qualify_reg     <= 1'b0;
            illegal_reg     <= 1'b0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_control_reg <= 4'b0000;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            res_branch_reg  <= 1'b0;
            res_illegal_reg <= 1'b0;
            op_count_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_a_reg       <= rs_data;
                        alu_b_reg       <= operand_b;
                        alu_control_reg <= dec_control;
                        illegal_reg     <= dec_illegal;
                        qualify_reg     <= (alu_op == 2'b01);
                        state_reg       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has had a full cycle to settle on the held operands.
                    res_data_reg    <= alu_result;
                    res_branch_reg  <= alu_zero & qualify_reg;
                    res_illegal_reg <= illegal_reg;
                    res_valid_reg   <= 1'b1;
                    if (!(&op_count_reg)) begin
                        op_count_reg <= op_count_reg + 1'b1;
                    end
                    state_reg       <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_control = alu_control_reg;
    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign res_branch  = res_branch_reg;
    assign res_illegal = res_illegal_reg;
    assign op_count    = op_count_reg;

endmodule
